// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and controller state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_seq_core.sv
// Single-cycle combinational datapath for arithmetic/logic opcodes.
// Shift opcodes are legal here but produce nothing; the controller iterates them.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_OP   = 6
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic [N_OP-1:0]   op,
  output logic [N_BITS-1:0] rdo,
  output logic              carry,
  output logic              overflow,
  output logic              op_err
);

  logic [N_BITS:0] sum;
  logic [N_BITS:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    rdo      = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    op_err   = 1'b0;
    case (op)
      N_OP'(OP_ADD): begin
        rdo      = sum[N_BITS-1:0];
        carry    = sum[N_BITS];
        overflow = (a[N_BITS-1] == b[N_BITS-1]) && (sum[N_BITS-1] != a[N_BITS-1]);
      end
      // diff[N_BITS] is the borrow: set exactly when a < b unsigned
      N_OP'(OP_SUB): begin
        rdo      = diff[N_BITS-1:0];
        carry    = diff[N_BITS];
        overflow = (a[N_BITS-1] != b[N_BITS-1]) && (diff[N_BITS-1] != a[N_BITS-1]);
      end
      N_OP'(OP_AND): rdo = a & b;
      N_OP'(OP_OR):  rdo = a | b;
      N_OP'(OP_XOR): rdo = a ^ b;
      N_OP'(OP_NOR): rdo = ~(a | b);
      N_OP'(OP_SLL), N_OP'(OP_SRL), N_OP'(OP_SRA): op_err = 1'b0;
      default:       op_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one transaction at a time, shifts iterate one bit
// per cycle; results and flags are held until the consumer takes them.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_OP   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic [N_OP-1:0]   op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] rdo,
  output logic              carry,
  output logic              zero,
  output logic              negative,
  output logic              overflow,
  output logic              op_err
);

  localparam int unsigned     CW     = $clog2(N_BITS + 1);
  localparam logic [N_BITS:0] NB_EXT = (N_BITS + 1)'(N_BITS);

  state_e            state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
  logic [N_OP-1:0]   op_q, op_d;
  logic [N_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_BITS-1:0] rdo_q, rdo_d;
  logic              carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
  logic              ovf_q, ovf_d, err_q, err_d;

  logic [N_BITS-1:0] core_rdo;
  logic              core_carry, core_ovf, core_err;
  logic              is_sll, is_srl, is_sra, is_shift;
  logic [CW-1:0]     shift_amt;
  logic [N_BITS-1:0] sh_step;
  logic              sh_out;

  alu_core #(
    .N_BITS(N_BITS),
    .N_OP  (N_OP)
  ) u_core (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .rdo     (core_rdo),
    .carry   (core_carry),
    .overflow(core_ovf),
    .op_err  (core_err)
  );

  assign is_sll    = (op_q == N_OP'(OP_SLL));
  assign is_srl    = (op_q == N_OP'(OP_SRL));
  assign is_sra    = (op_q == N_OP'(OP_SRA));
  assign is_shift  = is_sll | is_srl | is_sra;
  assign shift_amt = ({1'b0, b_q} >= NB_EXT) ? CW'(N_BITS) : CW'(b_q);

  always_comb begin
    sh_step = sh_q;
    sh_out  = 1'b0;
    if (is_sll) begin
      sh_step = {sh_q[N_BITS-2:0], 1'b0};
      sh_out  = sh_q[N_BITS-1];
    end else if (is_srl) begin
      sh_step = {1'b0, sh_q[N_BITS-1:1]};
      sh_out  = sh_q[0];
    end else if (is_sra) begin
      sh_step = {sh_q[N_BITS-1], sh_q[N_BITS-1:1]};
      sh_out  = sh_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    rdo_d   = rdo_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_shift) begin
          sh_d  = a_q;
          cnt_d = shift_amt;
          if (shift_amt == '0) begin
            rdo_d   = a_q;
            carry_d = 1'b0;
            zero_d  = (a_q == '0);
            neg_d   = a_q[N_BITS-1];
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          rdo_d   = core_rdo;
          carry_d = core_carry;
          zero_d  = (core_rdo == '0);
          neg_d   = core_rdo[N_BITS-1];
          ovf_d   = core_ovf;
          err_d   = core_err;
          state_d = ST_DONE;
        end
      end
      // Result registers are only written on the final step so DONE sees a clean set
      ST_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          rdo_d   = sh_step;
          carry_d = sh_out;
          zero_d  = (sh_step == '0);
          neg_d   = sh_step[N_BITS-1];
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      rdo_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      rdo_q   <= rdo_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign rdo       = rdo_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign op_err    = err_q;

endmodule
